// File: rtl/wb_pkg.sv
// Shared types and sizing for the dmem posted-store write buffer.
package wb_pkg;

    localparam int WB_N     = 32;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [WB_N-1:0] addr;
        logic [WB_N-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first store-to-load match over the write buffer entries.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            valid,
    input  wb_entry_t [DEPTH-1:0]       entries,
    input  logic [AW-1:0]               tail,
    input  logic [WB_N-1:0]             addr,
    output logic                        hit,
    output logic [WB_N-1:0]             data
);

    logic [AW-1:0] idx;

    // Walk oldest to youngest (tail-DEPTH .. tail-1) so the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail - AW'(i);
            if (valid[idx] && entries[idx].addr[WB_N-1:2] == addr[WB_N-1:2]) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store FIFO between the core data port and dmem, with load forwarding.
module dmem_write_buffer
    import wb_pkg::*;
#(
    parameter int n     = WB_N,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        memwrite,
    input  logic [n-1:0]                dataadr,
    input  logic [n-1:0]                writedata,
    input  logic                        memread,
    output logic                        stall,
    output logic                        fwd_hit,
    output logic [n-1:0]                fwd_data,
    output logic                        mem_we,
    output logic [n-1:0]                mem_addr,
    output logic [n-1:0]                mem_wd,
    input  logic                        mem_ready,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [AW-1:0]         head, tail;
    logic                  full, push, pop;
    logic                  m_hit;
    logic [n-1:0]          m_data;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign push   = memwrite & ~full;
    assign mem_we = ~empty;
    assign pop    = mem_we & mem_ready;
    // Stall looks only at registered occupancy so mem_ready stays off the core path.
    assign stall  = memwrite & full;

    assign mem_addr = mem_we ? entries[head].addr : '0;
    assign mem_wd   = mem_we ? entries[head].data : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + AW'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; valid bits and mem_we gating hide stale data.
    always_ff @(posedge clk) begin
        if (push)
            entries[tail] <= '{addr: dataadr, data: writedata};
    end

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
        .valid   (valid),
        .entries (entries),
        .tail    (tail),
        .addr    (dataadr),
        .hit     (m_hit),
        .data    (m_data)
    );

    assign fwd_hit  = memread & m_hit;
    assign fwd_data = fwd_hit ? m_data : '0;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed scoreboard bench for dmem_write_buffer.
module tb_dmem_write_buffer;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite, memread, mem_ready;
    logic [31:0] dataadr, writedata;
    logic        stall, fwd_hit, mem_we, empty;
    logic [31:0] fwd_data, mem_addr, mem_wd;
    logic [2:0]  count;

    int n_pass = 0;
    int n_total = 0;

    wb_entry_t exp_q[$];

    always #5 clk = ~clk;

    dmem_write_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .memread   (memread),
        .stall     (stall),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_ready (mem_ready),
        .count     (count),
        .empty     (empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue an accepted store this cycle and record what dmem must later see.
    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic idle();
        memwrite = 1'b0;
        memread  = 1'b0;
    endtask

    // Monitor: every dmem handshake must match the oldest outstanding store.
    always @(negedge clk) begin
        if (reset && mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                chk("dmem_unexpected_write", mem_addr, 32'hDEAD_BEEF);
            end else begin
                chk("dmem_addr", mem_addr, exp_q[0].addr);
                chk("dmem_data", mem_wd, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b0; memwrite = 0; memread = 0; mem_ready = 0;
        dataadr = 0; writedata = 0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd_hit", 32'(fwd_hit), 0);
        chk("rst_fwd_data", fwd_data, 0);

        // Reset mid-drain with three pending stores
        step(); reset = 1'b1; sw(32'h100, 32'h1);
        step(); sw(32'h104, 32'h2);
        step(); sw(32'h108, 32'h3);
        step(); idle();
        @(negedge clk);
        chk("pre_rst_count", 32'(count), 3);
        step(); reset = 1'b0; mem_ready = 1'b1; exp_q.delete();
        step();
        @(negedge clk);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_mem_we", 32'(mem_we), 0);
        memwrite = 1'b1;
        #1 chk("midrst_stall", 32'(stall), 0);
        memwrite = 1'b0;
        step(); reset = 1'b1;

        // Single store
        step(); sw(32'd84, 32'h96);
        @(negedge clk);
        chk("single_we_before", 32'(mem_we), 0);
        step(); idle();
        @(negedge clk);
        chk("single_we", 32'(mem_we), 1);
        chk("single_addr", mem_addr, 32'd84);
        chk("single_wd", mem_wd, 32'h96);
        step();
        @(negedge clk);
        chk("single_empty", 32'(empty), 1);

        // Fill and stall
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); sw(32'(4*i), 32'h10 + 32'(i));
        end
        step(); memwrite = 1'b1; dataadr = 32'd16; writedata = 32'h14;
        @(negedge clk);
        chk("fill_count", 32'(count), 4);
        chk("fill_stall", 32'(stall), 1);
        step(); mem_ready = 1'b1;
        @(negedge clk);
        chk("stall_during_pop", 32'(stall), 1);
        step(); exp_q.push_back('{addr: 32'd16, data: 32'h14});
        @(negedge clk);
        chk("stall_released", 32'(stall), 0);
        chk("released_count", 32'(count), 3);
        step(); idle();
        @(negedge clk);
        chk("pushpop_full_count", 32'(count), 3);
        repeat (3) step();
        @(negedge clk);
        chk("fill_drained", 32'(empty), 1);

        // Forwarding: youngest wins, low address bits ignored
        mem_ready = 1'b0;
        step(); sw(32'd84, 32'hAA);
        step(); sw(32'd84, 32'hBB);
        step(); idle(); memread = 1'b1; dataadr = 32'd84;
        @(negedge clk);
        chk("fwd_hit", 32'(fwd_hit), 1);
        chk("fwd_youngest", fwd_data, 32'hBB);
        dataadr = 32'd86;
        #1 chk("fwd_lowbits", fwd_data, 32'hBB);
        dataadr = 32'd88;
        #1 chk("fwd_miss_hit", 32'(fwd_hit), 0);
        chk("fwd_miss_data", fwd_data, 0);
        memread = 1'b0; dataadr = 32'd84;
        #1 chk("fwd_noread", 32'(fwd_hit), 0);
        step(); mem_ready = 1'b1; memread = 1'b1; dataadr = 32'd84;
        @(negedge clk);
        chk("fwd_while_pop", fwd_data, 32'hBB);
        step();
        @(negedge clk);
        chk("fwd_last_entry", fwd_data, 32'hBB);
        step(); idle();
        @(negedge clk);
        chk("fwd_after_drain", 32'(fwd_hit), 0);

        // Wrap: store/drain pairs
        for (int i = 0; i < 10; i++) begin
            step(); sw(32'h200 + 32'(4*i), 32'h1000 + 32'(i));
            @(negedge clk);
            chk("wrap_cnt_le1", 32'(count <= 3'd1), 1);
            step(); idle();
            @(negedge clk);
            chk("wrap_cnt_one", 32'(count), 1);
        end
        step();
        @(negedge clk);
        chk("wrap_empty", 32'(empty), 1);

        // Push+pop at count=2
        mem_ready = 1'b0;
        step(); sw(32'h300, 32'hA0);
        step(); sw(32'h304, 32'hA1);
        step(); sw(32'h308, 32'hA2); mem_ready = 1'b1;
        @(negedge clk);
        chk("pp_count_before", 32'(count), 2);
        chk("pp_head_before", mem_addr, 32'h300);
        step(); idle(); mem_ready = 1'b0; memread = 1'b1; dataadr = 32'h308;
        @(negedge clk);
        chk("pp_count_after", 32'(count), 2);
        chk("pp_head_after", mem_addr, 32'h304);
        chk("pp_tail_fwd", fwd_data, 32'hA2);
        step(); idle(); mem_ready = 1'b1;

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) step();
        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("final_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
